sliding_window_buffer: RTL
==========================

SLIDING_WINDOW_BUFFER -- requirements
Module: sliding_window_buffer

Interface
REQ-001 The module SHALL have parameter KERNEL_SIZE, default 3, meaning window height and width K (K >= 2).
REQ-002 The module SHALL have parameter DATA_SIZE, default 8, meaning pixel width in bits.
REQ-003 The module SHALL have parameter ROW_SIZE, default 28, meaning pixels per image row W (W >= K).
REQ-004 The module SHALL have parameter COL_SIZE, default 28, meaning rows per image H (H >= K).
REQ-005 The module SHALL have parameter STRIDE, default 1, meaning window step S in both directions (S >= 1).
REQ-006 The module SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The module SHALL have port resetn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-008 The module SHALL have port start_frame, input, 1 bit: synchronous frame restart pulse.
REQ-009 The module SHALL have port data_valid, input, 1 bit: pixel_in is valid this cycle.
REQ-010 The module SHALL have port pixel_in, input, DATA_SIZE bits: raster-order pixel, row-major.
REQ-011 The module SHALL have port window_out, output, K*K*DATA_SIZE bits: current KxK window.
REQ-012 The module SHALL have port window_valid, output, 1 bit: window_out holds a legal window this cycle.
REQ-013 The module SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last pixel of a frame.

Function
REQ-014 A pixel SHALL be accepted on every rising edge with data_valid=1; no backpressure; gaps of any length SHALL be tolerated without state change.
REQ-015 Storage SHALL be K-1 row delay lines of W entries each, plus a KxK register window; all shift only on accepted pixels.
REQ-016 Column counter c (0..W-1) and row counter r (0..H-1) SHALL track the coordinate of the accepted pixel; c wraps W-1->0 with r incrementing; r wraps H-1->0 after the last pixel.
REQ-017 Window layout: window_out[((i*K)+j)*DATA_SIZE +: DATA_SIZE] SHALL hold the pixel at image (r-K+1+i, c-K+1+j), i=0 oldest row, j=0 leftmost column.
REQ-018 A window SHALL be legal when r >= K-1, c >= K-1, (r-K+1) mod S = 0 and (c-K+1) mod S = 0; modulo via step counters, no dividers.
REQ-019 window_valid SHALL assert exactly one cycle, on the cycle after the accepting edge of a pixel that makes the window legal; latency = 1 clock from accepting edge.
REQ-020 window_out SHALL stay stable when window_valid=0 and no pixel is accepted.
REQ-021 Windows SHALL never span a row boundary; columns wrapping from row end to next row start SHALL not produce a legal window.
REQ-022 frame_done SHALL pulse for one cycle, coincident with the window_valid of the last pixel (r=H-1, c=W-1) accepted.
REQ-023 Next frame SHALL start at r=0, c=0 automatically; stale delay-line contents SHALL not cause an early window_valid (gating by counters).
REQ-024 start_frame=1 SHALL clear c, r and step counters and deassert window_valid/frame_done next cycle; delay-line data need not be cleared.
REQ-025 start_frame and data_valid together SHALL restart the frame and accept that pixel as (0,0).
REQ-026 No arithmetic on pixel data; counters SHALL be sized $clog2 of their range (minimum 1 bit).

Reset
REQ-027 resetn=0 SHALL asynchronously clear c, r, step counters, window_valid=0, frame_done=0, window_out=0.
REQ-028 Delay-line contents need not be reset; after resetn release, behaviour SHALL equal a fresh frame start.
REQ-029 Reset asserted mid-frame SHALL abort the frame; no window_valid or frame_done SHALL appear from the aborted frame.

Verification
REQ-030 K=3, W=H=5, S=1, pixels 0..24 continuous -> 9 window_valid pulses; first one cycle after pixel 12 with window {0,1,2,5,6,7,10,11,12}; last {12,13,14,17,18,19,22,23,24} with frame_done.
REQ-031 Same with S=2 -> exactly 4 windows, after pixels 12, 14, 22, 24.
REQ-032 Same as REQ-030 with random data_valid gaps (0-3 idle cycles) -> identical window sequence, window_out stable across gaps.
REQ-033 Two back-to-back frames 0..24 then 100..124 -> second frame first window {100,101,102,105,106,107,110,111,112}, no window before pixel 112.
REQ-034 resetn pulsed low after pixel 8, then frame 0..24 -> no output before reset; full REQ-030 sequence after.
REQ-035 start_frame with data_valid on pixel 7 of a frame, then 24 more pixels -> that pixel treated as (0,0); 9 windows relative to it.

Source files
------------

// File: rtl/sliding_window_buffer.sv
// sliding_window_buffer
//
// Purpose:
//   Turns a raster-order pixel stream into KxK image windows for a
//   convolution-style consumer. K-1 row delay lines supply the older rows,
//   and a KxK register window shifts left by one column per accepted pixel.
//   Column/row counters plus stride phase counters decide when the window
//   lines up with a legal KxK position on the stride grid.
//
// Ports:
//   clock        in   single clock, rising edge
//   resetn       in   asynchronous active-low reset
//   start_frame  in   synchronous frame restart pulse
//   data_valid   in   pixel_in is valid this cycle (no backpressure)
//   pixel_in     in   DATA_SIZE-bit raster-order pixel
//   window_out   out  K*K*DATA_SIZE bits; slot (i*K+j) = pixel (r-K+1+i, c-K+1+j)
//   window_valid out  one-cycle pulse: window_out holds a legal window
//   frame_done   out  one-cycle pulse after the last pixel of the frame

module sliding_window_buffer #(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_SIZE   = 8,
    parameter int ROW_SIZE    = 28,
    parameter int COL_SIZE    = 28,
    parameter int STRIDE      = 1
) (
    input  logic                                       clock,
    input  logic                                       resetn,
    input  logic                                       start_frame,
    input  logic                                       data_valid,
    input  logic [DATA_SIZE-1:0]                       pixel_in,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_SIZE-1:0] window_out,
    output logic                                       window_valid,
    output logic                                       frame_done
);

    localparam int K = KERNEL_SIZE;
    localparam int D = DATA_SIZE;
    localparam int W = ROW_SIZE;
    localparam int H = COL_SIZE;
    localparam int S = STRIDE;

    localparam int COL_W  = (W > 1) ? $clog2(W) : 1;
    localparam int ROW_W  = (H > 1) ? $clog2(H) : 1;
    localparam int STEP_W = (S > 1) ? $clog2(S) : 1;

    localparam logic [COL_W-1:0]  COL_LAST      = COL_W'(W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST      = ROW_W'(H - 1);
    localparam logic [COL_W-1:0]  COL_FIRST_WIN = COL_W'(K - 1);
    localparam logic [ROW_W-1:0]  ROW_FIRST_WIN = ROW_W'(K - 1);
    localparam logic [STEP_W-1:0] STEP_LAST     = STEP_W'(S - 1);

    // Row delay lines: lineQ[m][W-1] is the pixel accepted W*(m+1) pixels ago.
    logic [D-1:0] lineQ [0:K-2][0:W-1];

    // Register window: winQ[i][j] is image pixel (r-K+1+i, c-K+1+j).
    logic [D-1:0] winQ [0:K-1][0:K-1];

    // Column entering each window row: newest row straight from the input,
    // older rows from progressively deeper delay-line outputs.
    logic [D-1:0] tap [0:K-1];

    logic [COL_W-1:0]  colQ, colD, effCol;
    logic [ROW_W-1:0]  rowQ, rowD, effRow;
    logic [STEP_W-1:0] colStepQ, colStepD, effColStep;
    logic [STEP_W-1:0] rowStepQ, rowStepD, effRowStep;
    logic              windowValidQ, windowValidD;
    logic              frameDoneQ, frameDoneD;

    logic accept;
    logic colLast;
    logic rowLast;
    logic legal;

    assign accept = data_valid;

    always_comb begin
        tap[K-1] = pixel_in;
        for (int m = 0; m < K - 1; m++) begin
            tap[K-2-m] = lineQ[m][W-1];
        end
    end

    // Delay lines carry data only; they are never reset because the
    // counters keep stale contents from ever reaching a valid window.
    always_ff @(posedge clock) begin
        if (accept) begin
            lineQ[0][0] <= pixel_in;
            for (int m = 1; m < K - 1; m++) begin
                lineQ[m][0] <= lineQ[m-1][W-1];
            end
            for (int m = 0; m < K - 1; m++) begin
                for (int e = 1; e < W; e++) begin
                    lineQ[m][e] <= lineQ[m][e-1];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    winQ[i][j] <= '0;
                end
            end
        end else if (accept) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) begin
                    winQ[i][j] <= winQ[i][j+1];
                end
                winQ[i][K-1] <= tap[i];
            end
        end
    end

    // start_frame overrides the stored position so a pixel arriving with it
    // is handled as coordinate (0,0) in the same cycle.
    // Step counters hold (coord-K+1) mod S once coord >= K-1, and 0 before,
    // so the stride test is a compare against zero.
    always_comb begin
        effCol     = start_frame ? '0 : colQ;
        effRow     = start_frame ? '0 : rowQ;
        effColStep = start_frame ? '0 : colStepQ;
        effRowStep = start_frame ? '0 : rowStepQ;

        colLast = (effCol == COL_LAST);
        rowLast = (effRow == ROW_LAST);
        legal   = (effRow >= ROW_FIRST_WIN) && (effCol >= COL_FIRST_WIN) &&
                  (effColStep == '0) && (effRowStep == '0);

        colD         = effCol;
        rowD         = effRow;
        colStepD     = effColStep;
        rowStepD     = effRowStep;
        windowValidD = accept && legal;
        frameDoneD   = accept && colLast && rowLast;

        if (accept) begin
            if (colLast) begin
                colD     = '0;
                colStepD = '0;
                if (rowLast) begin
                    rowD     = '0;
                    rowStepD = '0;
                end else begin
                    rowD = effRow + ROW_W'(1);
                    if (effRow < ROW_FIRST_WIN || effRowStep == STEP_LAST) begin
                        rowStepD = '0;
                    end else begin
                        rowStepD = effRowStep + STEP_W'(1);
                    end
                end
            end else begin
                colD = effCol + COL_W'(1);
                if (effCol < COL_FIRST_WIN || effColStep == STEP_LAST) begin
                    colStepD = '0;
                end else begin
                    colStepD = effColStep + STEP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            colQ         <= '0;
            rowQ         <= '0;
            colStepQ     <= '0;
            rowStepQ     <= '0;
            windowValidQ <= 1'b0;
            frameDoneQ   <= 1'b0;
        end else begin
            colQ         <= colD;
            rowQ         <= rowD;
            colStepQ     <= colStepD;
            rowStepQ     <= rowStepD;
            windowValidQ <= windowValidD;
            frameDoneQ   <= frameDoneD;
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < K; gi++) begin : gRow
            for (gj = 0; gj < K; gj++) begin : gCol
                assign window_out[((gi*K)+gj)*D +: D] = winQ[gi][gj];
            end
        end
    endgenerate

    assign window_valid = windowValidQ;
    assign frame_done   = frameDoneQ;

endmodule
